// File: rtl/bytebasher_pkg.sv
// Shared types and constants for the ByteBasher hit input path.
package bytebasher_pkg;

  localparam int CODE_W = 3;
  localparam logic [CODE_W-1:0] CODE_IDLE = 3'd0;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } hit_state_e;

endpackage

// File: rtl/gpio_hit_decoder_if.sv
// Valid/ready hit-event channel from the decoder to the game logic.
interface gpio_hit_decoder_if;
  import bytebasher_pkg::*;

  logic              hit_valid;
  logic              hit_ready;
  logic [CODE_W-1:0] hit_code;

  modport master (output hit_valid, output hit_code, input hit_ready);
  modport slave  (input hit_valid, input hit_code, output hit_ready);

endinterface

// File: rtl/hit_fifo.sv
// Small synchronous FIFO; a push into a full queue without a same-cycle pop is dropped.
module hit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && !do_push;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gpio_hit_decoder.sv
// Synchronises and debounces the raw GPIO hit code, turning each press into one queued hit event.
module gpio_hit_decoder
  import bytebasher_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic [CODE_W-1:0]           gpio_code,
  input  logic                        clear_overflow,
  gpio_hit_decoder_if.master          hit,
  output logic [CODE_W-1:0]           code_stable,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][CODE_W-1:0] sync_q;
  logic [CODE_W-1:0]                  sync_code;
  logic [CODE_W-1:0]                  cand;
  logic [CNT_W-1:0]                   cnt;
  logic                               qualify;
  hit_state_e                         state, state_next;
  logic                               fsm_push;
  logic                               fifo_full, fifo_empty, fifo_drop;
  logic [CODE_W-1:0]                  fifo_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_code};
  end

  assign sync_code = sync_q[SYNC_STAGES-1];
  assign qualify   = (sync_code == cand) && (cnt == CNT_W'(STABLE_CYCLES - 1));

  // A level is accepted on the edge its run of identical samples reaches STABLE_CYCLES.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cand        <= CODE_IDLE;
      cnt         <= '0;
      code_stable <= CODE_IDLE;
    end else begin
      if (sync_code != cand) begin
        cand <= sync_code;
        cnt  <= CNT_W'(1);
      end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
      if (qualify) code_stable <= cand;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
  always_comb begin
    state_next = state;
    fsm_push   = 1'b0;
    case (state)
      IDLE: if (qualify && cand != CODE_IDLE) begin
        fsm_push   = 1'b1;
        state_next = HELD;
      end
      HELD: if (qualify && cand == CODE_IDLE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .push      (fsm_push),
    .push_data (cand),
    .pop       (hit.hit_valid && hit.hit_ready),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign hit.hit_valid = !fifo_empty;
  assign hit.hit_code  = fifo_data;

  // A drop and a clear on the same edge leave the flag set.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                     overflow <= 1'b0;
    else if (fifo_drop && fifo_full) overflow <= 1'b1;
    else if (clear_overflow)         overflow <= 1'b0;
  end

endmodule
